// File: rtl/apb_req_arbiter.sv
// Two-requester round-robin arbiter that serialises read/write commands onto
// the APB master bridge and routes the completion (or timeout) back to the owner.
module apb_req_arbiter #(
  parameter int AW      = 9,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          req0_valid,
  input  logic          req0_write,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic          req1_write,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          resp0_valid,
  output logic          resp0_err,
  output logic [DW-1:0] resp0_rdata,
  output logic          resp1_valid,
  output logic          resp1_err,
  output logic [DW-1:0] resp1_rdata,
  output logic          transfer,
  output logic          read_write,
  output logic [AW-1:0] apb_write_paddr,
  output logic [DW-1:0] apb_write_data,
  output logic [AW-1:0] apb_read_paddr,
  input  logic [DW-1:0] apb_read_data_out,
  input  logic          xfer_done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state_reg;
  logic          last_grant_reg;
  logic          owner_reg;
  logic          write_reg;
  logic          rw_reg;
  logic          err_reg;
  logic [CW-1:0] cnt_reg;
  logic [AW-1:0] waddr_reg;
  logic [AW-1:0] raddr_reg;
  logic [DW-1:0] wdata_reg;
  logic [DW-1:0] rdata_reg;

  logic          grant0;
  logic          grant1;
  logic          accept;
  logic          sel_write;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // On a tie the requester that did not win last time gets the grant.
  assign grant0 = req0_valid & (~req1_valid | last_grant_reg);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant_reg);
  assign accept = (state_reg == IDLE) & (grant0 | grant1);

  assign req0_ready = (state_reg == IDLE) & grant0;
  assign req1_ready = (state_reg == IDLE) & grant1;

  assign sel_write = grant1 ? req1_write : req0_write;
  assign sel_addr  = grant1 ? req1_addr  : req0_addr;
  assign sel_wdata = grant1 ? req1_wdata : req0_wdata;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      write_reg      <= 1'b0;
      rw_reg         <= 1'b0;
      err_reg        <= 1'b0;
      cnt_reg        <= '0;
      waddr_reg      <= '0;
      raddr_reg      <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            owner_reg      <= grant1;
            last_grant_reg <= grant1;
            write_reg      <= sel_write;
            rw_reg         <= ~sel_write;
            cnt_reg        <= '0;
            if (sel_write) begin
              waddr_reg <= sel_addr;
              wdata_reg <= sel_wdata;
            end else begin
              raddr_reg <= sel_addr;
            end
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          // Completion takes priority over a timeout landing on the same edge.
          if (xfer_done) begin
            rdata_reg <= write_reg ? '0 : apb_read_data_out;
            err_reg   <= 1'b0;
            state_reg <= RESP;
          end else if (cnt_reg == CNT_LAST) begin
            rdata_reg <= '0;
            err_reg   <= 1'b1;
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign transfer        = (state_reg == BUSY);
  assign read_write      = rw_reg;
  assign apb_write_paddr = waddr_reg;
  assign apb_write_data  = wdata_reg;
  assign apb_read_paddr  = raddr_reg;

  assign resp0_valid = (state_reg == RESP) & ~owner_reg;
  assign resp1_valid = (state_reg == RESP) &  owner_reg;
  assign resp0_err   = resp0_valid & err_reg;
  assign resp1_err   = resp1_valid & err_reg;
  assign resp0_rdata = resp0_valid ? rdata_reg : '0;
  assign resp1_rdata = resp1_valid ? rdata_reg : '0;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: the bench plays both requesters and the
// bridge, and checks grants, bridge drive, responses, timeout and reset.
module tb_apb_req_arbiter;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int TIMEOUT = 16;

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_write = 1'b0, req1_write = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
  logic          req0_ready, req1_ready;
  logic          resp0_valid, resp1_valid, resp0_err, resp1_err;
  logic [DW-1:0] resp0_rdata, resp1_rdata;
  logic          transfer, read_write;
  logic [AW-1:0] apb_write_paddr, apb_read_paddr;
  logic [DW-1:0] apb_write_data;
  logic [DW-1:0] apb_read_data_out = '0;
  logic          xfer_done = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  apb_req_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .presetn(presetn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_err(resp0_err), .resp0_rdata(resp0_rdata),
    .resp1_valid(resp1_valid), .resp1_err(resp1_err), .resp1_rdata(resp1_rdata),
    .transfer(transfer), .read_write(read_write),
    .apb_write_paddr(apb_write_paddr), .apb_write_data(apb_write_data),
    .apb_read_paddr(apb_read_paddr), .apb_read_data_out(apb_read_data_out),
    .xfer_done(xfer_done)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the falling edge.
  task automatic step();
    @(negedge pclk);
    #1;
  endtask

  // Captured results of the last served transaction.
  int            t_owner, t_hi;
  logic          t_rw, t_v0, t_v1, t_err, t_rdy_resp;
  logic [AW-1:0] t_waddr, t_raddr;
  logic [DW-1:0] t_wdata, t_rdata, t_other;

  // Wait for a grant, act as the bridge (xfer_done after done_cyc BUSY cycles,
  // 0 = never) and capture the response cycle.
  task automatic serve(input int done_cyc, input logic [DW-1:0] rd_ret, input bit clr);
    bit got_resp;
    int wait_cnt;
    #1;
    got_resp = 0;
    wait_cnt = 0;
    apb_read_data_out = rd_ret;
    while (!(req0_ready | req1_ready) && wait_cnt < 10) begin
      step();
      wait_cnt++;
    end
    check("grant_seen", {31'd0, req0_ready ^ req1_ready}, 32'd1);
    t_owner = req1_ready ? 1 : 0;
    t_hi = 0;
    for (int i = 0; i < 40 && !got_resp; i++) begin
      step();
      if (transfer) begin
        t_hi++;
        if (t_hi == 1) begin
          t_rw = read_write;
          t_waddr = apb_write_paddr;
          t_wdata = apb_write_data;
          t_raddr = apb_read_paddr;
          if (clr) begin
            if (t_owner == 0) req0_valid = 1'b0;
            else req1_valid = 1'b0;
          end
        end
        xfer_done = (t_hi == done_cyc);
      end else if (t_hi > 0) begin
        xfer_done = 1'b0;
        got_resp = 1;
        t_v0 = resp0_valid;
        t_v1 = resp1_valid;
        t_err = t_owner ? resp1_err : resp0_err;
        t_rdata = t_owner ? resp1_rdata : resp0_rdata;
        t_other = t_owner ? resp0_rdata : resp1_rdata;
        t_rdy_resp = req0_ready | req1_ready;
      end
    end
    xfer_done = 1'b0;
    check("resp_reached", {31'd0, got_resp}, 32'd1);
    $display("txn owner=%0d hi=%0d rw=%0b v0=%0b v1=%0b err=%0b rdata=0x%0h",
             t_owner, t_hi, t_rw, t_v0, t_v1, t_err, t_rdata);
  endtask

  initial begin
    // Reset state.
    #12;
    check("rst_transfer", {31'd0, transfer}, 0);
    check("rst_read_write", {31'd0, read_write}, 0);
    check("rst_waddr", {23'd0, apb_write_paddr}, 0);
    check("rst_wdata", {24'd0, apb_write_data}, 0);
    check("rst_raddr", {23'd0, apb_read_paddr}, 0);
    check("rst_resp", {30'd0, resp0_valid, resp1_valid}, 0);
    step();
    presetn = 1'b1;
    step();

    // xfer_done outside BUSY is ignored.
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    step();
    check("idle_done_transfer", {31'd0, transfer}, 0);
    check("idle_done_resp", {30'd0, resp0_valid, resp1_valid}, 0);

    // req0 write 0x005 <- 0xA5, done after 3 BUSY cycles.
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 9'h005; req0_wdata = 8'hA5;
    serve(3, 8'hEE, 1);
    check("w_owner", t_owner, 0);
    check("w_hi", t_hi, 3);
    check("w_rw", {31'd0, t_rw}, 0);
    check("w_paddr", {23'd0, t_waddr}, 32'h005);
    check("w_pdata", {24'd0, t_wdata}, 32'hA5);
    check("w_valid", {30'd0, t_v0, t_v1}, 32'b10);
    check("w_err", {31'd0, t_err}, 0);
    check("w_rdata", {24'd0, t_rdata}, 0);

    // req1 read 0x102, bridge returns 0x3C.
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 9'h102;
    serve(2, 8'h3C, 1);
    check("r_owner", t_owner, 1);
    check("r_rw", {31'd0, t_rw}, 1);
    check("r_raddr", {23'd0, t_raddr}, 32'h102);
    check("r_valid", {30'd0, t_v0, t_v1}, 32'b01);
    check("r_rdata", {24'd0, t_rdata}, 32'h3C);
    check("r_other_rdata", {24'd0, t_other}, 0);
    check("r_err", {31'd0, t_err}, 0);

    // Both requesters held valid for four back-to-back transactions.
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 9'h011;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 9'h122; req1_wdata = 8'h5A;
    for (int k = 0; k < 4; k++) begin
      serve(1, 8'h40 + 8'(k), 0);
      check("rr_owner", t_owner, k % 2);
      check("rr_hi", t_hi, 1);
      check("rr_ready_in_resp", {31'd0, t_rdy_resp}, 0);
      check("rr_valid", {30'd0, t_v0, t_v1}, (k % 2) ? 32'b01 : 32'b10);
      check("rr_rdata", {24'd0, t_rdata}, (k % 2) ? 32'h00 : 32'h40 + k);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Timeout: xfer_done never arrives.
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 9'h033;
    serve(0, 8'h77, 1);
    check("to_hi", t_hi, TIMEOUT);
    check("to_err", {31'd0, t_err}, 1);
    check("to_rdata", {24'd0, t_rdata}, 0);

    // Next request serviced normally; done coincides with the last count.
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 9'h144;
    serve(TIMEOUT, 8'hC3, 1);
    check("edge_owner", t_owner, 1);
    check("edge_hi", t_hi, TIMEOUT);
    check("edge_err", {31'd0, t_err}, 0);
    check("edge_rdata", {24'd0, t_rdata}, 32'hC3);

    // req0 read, then reset in its 2nd BUSY cycle.
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 9'h0AB;
    serve(1, 8'h12, 1);
    check("pre_rst_owner", t_owner, 0);
    req0_valid = 1'b1;
    step();
    check("pre_rst_ready", {31'd0, req0_ready}, 1);
    step();
    req0_valid = 1'b0;
    check("busy1_transfer", {31'd0, transfer}, 1);
    step();
    presetn = 1'b0;
    #1;
    check("rst_async_transfer", {31'd0, transfer}, 0);
    check("rst_async_resp", {30'd0, resp0_valid, resp1_valid}, 0);
    step();
    check("rst_hold_resp", {30'd0, resp0_valid, resp1_valid}, 0);
    presetn = 1'b1;
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 9'h0CD; req0_wdata = 8'h99;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 9'h1EF;
    #1;
    check("post_rst_tie0", {30'd0, req0_ready, req1_ready}, 32'b10);
    serve(2, 8'h00, 1);
    check("post_rst_owner0", t_owner, 0);
    check("post_rst_wdata", {24'd0, t_wdata}, 32'h99);
    serve(2, 8'h66, 1);
    check("post_rst_owner1", t_owner, 1);
    check("post_rst_rdata", {24'd0, t_rdata}, 32'h66);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Two-requester arbiter and sequencer in front of the APB master bridge. It accepts read/write commands from two independent requesters and grants them round-robin. It drives the bridge's transfer/read_write/address/data inputs for one transaction at a time, returns read data or a timeout error to the owning requester, and guarantees the bridge never sees overlapping commands.

## Interface
Parameters:
- AW, 9, address width (bit AW-1 selects slave inside the bridge; passed through untouched)
- DW, 8, data width
- TIMEOUT, 16, max cycles in BUSY awaiting xfer_done before abort (≥2)

Ports (clock pclk; reset presetn, asynchronous, active-low):
- pclk  in  1  clock
- presetn  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  command request, held until accepted
- req0_write / req1_write  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  AW  target address
- req0_wdata / req1_wdata  in  DW  write data
- req0_ready / req1_ready  out  1  command accepted on edge where valid&ready
- resp0_valid / resp1_valid  out  1  one-cycle completion pulse
- resp0_err / resp1_err  out  1  timeout flag, valid with resp_valid
- resp0_rdata / resp1_rdata  out  DW  read data, valid with resp_valid
- transfer  out  1  bridge transaction request
- read_write  out  1  1 = read, 0 = write
- apb_write_paddr  out  AW  write address
- apb_write_data  out  DW  write data
- apb_read_paddr  out  AW  read address
- apb_read_data_out  in  DW  bridge read data
- xfer_done  in  1  bridge completion pulse (ACCESS with pready)

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: reqN_ready = grant_N (combinational); no other ready. Grant: only one valid → that one; both valid → the one not last granted. last_grant resets to 1, so req0 wins the first tie.
- Accept edge (valid&ready in IDLE): latch write, addr, wdata, owner; last_grant ← owner; timeout counter ← 0; → BUSY.
- BUSY: transfer = 1. read_write = ~latched write. Write: apb_write_paddr = addr, apb_write_data = wdata. Read: apb_read_paddr = addr. Counter increments every BUSY cycle.
- xfer_done sampled high in BUSY: capture apb_read_data_out (reads) or 0 (writes) into rdata; err ← 0; → RESP.
- Counter reaches TIMEOUT-1 with xfer_done low: rdata ← 0, err ← 1, → RESP. xfer_done and timeout on the same edge: done wins, err = 0.
- RESP, one cycle: transfer = 0; respN_valid = 1 for owner only, with err/rdata; → IDLE. Non-owner resp outputs are 0.
- xfer_done outside BUSY is ignored.
- Requests arriving in BUSY/RESP wait; ready stays 0.
- Address/data outputs to the bridge hold their last latched values outside BUSY; the bridge qualifies them with transfer.

## Timing
- Reset: state IDLE, last_grant = 1, counter 0. transfer, read_write, all addresses, data, resp_valid, resp_err, resp_rdata = 0.
- Reset asserted mid-BUSY forces transfer low immediately (asynchronous). The in-flight command is dropped with no response.
- Accept at edge T0 → transfer high from T0 through the xfer_done edge Td → resp_valid high in cycle Td..Td+1 → IDLE at Td+1. Next accept is no earlier than edge Td+1.
- Minimum turnaround: accept to resp_valid = 2 cycles (xfer_done on first BUSY edge). Transfer is low for ≥1 cycle between transactions.
- Timeout: transfer is high for exactly TIMEOUT cycles, then resp with err = 1.

## Test plan
- req0 write addr 0x005, data 0xA5; xfer_done 3 cycles after accept → transfer high 3 cycles, read_write = 0, apb_write_paddr = 0x005, apb_write_data = 0xA5; resp0_valid pulse, err = 0.
- req1 read addr 0x102, bridge returns 0x3C with xfer_done → read_write = 1, apb_read_paddr = 0x102, resp1_rdata = 0x3C, resp1_valid only.
- req0 and req1 both valid continuously for 4 transactions → grants 0,1,0,1. No transfer overlap; transfer low ≥1 cycle between transactions.
- TIMEOUT = 16, xfer_done never asserted → transfer high 16 cycles, resp_err = 1, rdata = 0; next request serviced normally.
- xfer_done on the same edge as the counter reaching 15 → err = 0, read data captured.
- presetn low in the 2nd BUSY cycle → transfer = 0 immediately, no resp_valid. After release, a tie grants req0 first.
